rice_core_scoreboard: RTL

- Register-hazard scoreboard and issue controller for the decode stage.
- Counts in-flight writes per architectural register and stalls decode when a source or destination conflicts with a pending write.
- Provides a drain sequence (all writes retired) for fence/system instructions.
- Sits beside the ID stage: driven by decode outputs (rs1/rs2/rd), drives the ID stall; fed by EX-stage cancel and WB-stage retire.

---
 rtl/rice_core_pkg.sv | 25 ++
 rtl/rice_core_scoreboard_if.sv | 25 ++
 rtl/rice_core_scoreboard_counter.sv | 60 ++++++
 rtl/rice_core_scoreboard.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rice_core_pkg.sv
// Shared types for the rice_core decode-side blocks: register index widths,
// the decode request payload and the scoreboard drain FSM states.
package rice_core_pkg;

  localparam int unsigned RICE_CORE_RS_W  = 5;
  localparam int unsigned RICE_CORE_RD_W  = 5;
  localparam int unsigned RICE_CORE_NREGS = 32;

  typedef logic [RICE_CORE_RS_W-1:0] rice_core_rs_t;
  typedef logic [RICE_CORE_RD_W-1:0] rice_core_rd_t;

  // Register operands of one decoded instruction (index 0 = unused / no write).
  typedef struct packed {
    rice_core_rs_t rs1;
    rice_core_rs_t rs2;
    rice_core_rd_t rd;
  } rice_core_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } rice_core_scoreboard_state_t;

endpackage

// File: rtl/rice_core_scoreboard_if.sv
// Decode/EX/WB hazard-tracking signals between the pipeline and the scoreboard.
// The master is the pipeline side; the slave is the scoreboard.
interface rice_core_scoreboard_if;
  import rice_core_pkg::*;

  logic           req_valid;
  rice_core_req_t req;
  logic           stall;
  logic           issue;
  logic           cancel_valid;
  rice_core_rd_t  cancel_rd;
  logic           retire_valid;
  rice_core_rd_t  retire_rd;

  modport master (
    output req_valid, req, cancel_valid, cancel_rd, retire_valid, retire_rd,
    input  stall, issue
  );

  modport slave (
    input  req_valid, req, cancel_valid, cancel_rd, retire_valid, retire_rd,
    output stall, issue
  );

endinterface

// File: rtl/rice_core_scoreboard_counter.sv
// One per-register in-flight write counter. Increment and both decrements are
// folded into a single net delta per cycle; the result is clamped to the
// counter range and out-of-range attempts are flagged by assertions.
module rice_core_scoreboard_counter #(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  input  logic                 i_dec_cancel,
  input  logic                 i_dec_retire,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_nz,
  output logic                 o_nz_next
);

  localparam int unsigned   SumW   = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic signed [SumW-1:0] sum_c;
  logic                 underflow_c;
  logic                 overflow_c;

  // Net delta and clamp into the counter range.
  always_comb begin
    sum_c = $signed({2'b00, cnt_q})
          + $signed(SumW'(i_inc))
          - $signed(SumW'(i_dec_cancel))
          - $signed(SumW'(i_dec_retire));
    underflow_c = sum_c[SumW-1];
    overflow_c  = !underflow_c && (sum_c > $signed({2'b00, CntMax}));
    cnt_d       = sum_c[CNT_WIDTH-1:0];
    if (underflow_c) begin
      cnt_d = '0;
    end else if (overflow_c) begin
      cnt_d = CntMax;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_nz      = (cnt_q != '0);
  assign o_nz_next = (cnt_d != '0);

  // More retires/cancels than writes in flight means an upstream bookkeeping bug.
  a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n) !underflow_c);
  // The saturation stall must keep issue from pushing past the maximum.
  a_no_overflow  : assert property (@(posedge i_clk) disable iff (!i_rst_n) !overflow_c);

endmodule

// File: rtl/rice_core_scoreboard.sv
// Register-hazard scoreboard and issue controller beside the ID stage.
// Tracks in-flight writes per architectural register, stalls decode on
// RAW/WAW-saturation conflicts, and runs a drain handshake for fences.
// Optional: RICE_CORE_SCOREBOARD_BYPASS_EN lets a source whose last pending
// write retires this cycle issue in the same cycle (write-first register file).
module rice_core_scoreboard
  import rice_core_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_flush,
  rice_core_scoreboard_if.slave       sb,
  input  logic                        i_drain_req,
  output logic                        o_drain_ack,
  output logic [RICE_CORE_NREGS-1:0]  o_pending,
  output logic                        o_busy
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]       cnt [RICE_CORE_NREGS];
  logic [RICE_CORE_NREGS-1:0] nz;
  logic [RICE_CORE_NREGS-1:0] nz_next;

  rice_core_scoreboard_state_t state_q, state_d;
  logic                        ack_q, ack_d;

  logic rs1_haz_c, rs2_haz_c, rd_sat_c, hazard_c;
  logic byp1_c, byp2_c;
  logic stall_c, issue_c;

  // x0 is never tracked.
  assign cnt[0]     = '0;
  assign nz[0]      = 1'b0;
  assign nz_next[0] = 1'b0;

  // One counter per architectural register x1..x31.
  for (genvar n = 1; n < RICE_CORE_NREGS; n++) begin : g_cnt
    rice_core_scoreboard_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_inc        (issue_c && (sb.req.rd == RICE_CORE_RD_W'(n))),
      .i_dec_cancel (sb.cancel_valid && (sb.cancel_rd == RICE_CORE_RD_W'(n))),
      .i_dec_retire (sb.retire_valid && (sb.retire_rd == RICE_CORE_RD_W'(n))),
      .o_cnt        (cnt[n]),
      .o_nz         (nz[n]),
      .o_nz_next    (nz_next[n])
    );
  end

`ifdef RICE_CORE_SCOREBOARD_BYPASS_EN
  // A source whose only pending write lands this cycle reads the new value.
  assign byp1_c = sb.retire_valid && (sb.retire_rd == sb.req.rs1) && (cnt[sb.req.rs1] == CntOne);
  assign byp2_c = sb.retire_valid && (sb.retire_rd == sb.req.rs2) && (cnt[sb.req.rs2] == CntOne);
`else
  assign byp1_c = 1'b0;
  assign byp2_c = 1'b0;
`endif

  // Hazard detection, stall and issue decision.
  always_comb begin
    rs1_haz_c = (sb.req.rs1 != '0) && (cnt[sb.req.rs1] != '0) && !byp1_c;
    rs2_haz_c = (sb.req.rs2 != '0) && (cnt[sb.req.rs2] != '0) && !byp2_c;
    rd_sat_c  = (sb.req.rd  != '0) && (cnt[sb.req.rd] == CntMax);
    hazard_c  = rs1_haz_c || rs2_haz_c || rd_sat_c;
    stall_c   = sb.req_valid && (hazard_c || (state_q != IDLE) || !i_enable);
    issue_c   = sb.req_valid && !stall_c && !i_flush && i_enable;
  end

  assign sb.stall = stall_c;
  assign sb.issue = issue_c;

  // Drain FSM: next state and ack; exit uses post-update counter values.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_drain_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (nz_next == '0) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered drain acknowledge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign o_drain_ack = ack_q;
  assign o_pending   = nz;
  assign o_busy      = |nz;

  // The datapath width is carried only for type sharing; keep it sane.
  a_xlen_sane : assert property (@(posedge i_clk) disable iff (!i_rst_n) (XLEN >= 32));

endmodule
